// File: rtl/timer_display.sv
// MM:SS front end for a 4-digit common-anode multiplexed 7-segment display.
// Snapshots the timer once per frame, converts to BCD, scans digits and gates the alarm blink.
module timer_display #(
   parameter int SCAN_DIV      = 100000,
   parameter int BLINK_HALF_MS = 250
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_1k,
   input  logic       en,
   input  logic [5:0] minutes,
   input  logic [5:0] seconds,
   input  logic       blink,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   // state  | meaning
   // ST_ON  | digits may be lit (blink inactive or in its visible phase)
   // ST_OFF | alarm blink dark phase, all outputs blanked

   localparam int SW = $clog2(SCAN_DIV);
   localparam int PW = (BLINK_HALF_MS > 1) ? $clog2(BLINK_HALF_MS) : 1;
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] PHASE_LAST = PW'(BLINK_HALF_MS - 1);
   localparam logic [6:0]    SEG_DASH   = 7'b0111111;
   localparam logic [6:0]    SEG_BLANK  = 7'b1111111;

   typedef enum logic {ST_ON = 1'b0, ST_OFF = 1'b1} blink_state_e;

   logic [SW-1:0] scan_cnt_q;
   logic [1:0]    digit_q;
   logic [5:0]    min_q, sec_q;
   blink_state_e  state_q;
   logic [PW-1:0] phase_q;
   logic [3:0]    an_q;
   logic [6:0]    seg_q;
   logic          dp_q;

   logic          scan_tc;
   logic          frame_wrap;
   logic [5:0]    field;
   logic [5:0]    rem;
   logic [3:0]    tens;
   logic [3:0]    bcd_digit;
   logic          blank;
   logic [3:0]    an_d;
   logic [6:0]    seg_d;
   logic          dp_d;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    seg_of = 7'b1000000;
         4'd1:    seg_of = 7'b1111001;
         4'd2:    seg_of = 7'b0100100;
         4'd3:    seg_of = 7'b0110000;
         4'd4:    seg_of = 7'b0011001;
         4'd5:    seg_of = 7'b0010010;
         4'd6:    seg_of = 7'b0000010;
         4'd7:    seg_of = 7'b1111000;
         4'd8:    seg_of = 7'b0000000;
         4'd9:    seg_of = 7'b0010000;
         default: seg_of = SEG_BLANK;
      endcase
   endfunction

   assign scan_tc    = (scan_cnt_q == SCAN_LAST);
   assign frame_wrap = scan_tc && (digit_q == 2'd3);
   assign field      = digit_q[1] ? min_q : sec_q;

   // Compare-subtract chain: 40/20/10 steps cover every value up to 59.
   always_comb begin
      rem  = field;
      tens = 4'd0;
      if (rem >= 6'd40) begin
         rem  = rem - 6'd40;
         tens = tens + 4'd4;
      end
      if (rem >= 6'd20) begin
         rem  = rem - 6'd20;
         tens = tens + 4'd2;
      end
      if (rem >= 6'd10) begin
         rem  = rem - 6'd10;
         tens = tens + 4'd1;
      end
      bcd_digit = digit_q[0] ? tens : 4'(rem);
   end

   always_comb begin
      blank = !en || (state_q == ST_OFF);
      an_d  = ~(4'b0001 << digit_q);
      seg_d = (field >= 6'd60) ? SEG_DASH : seg_of(bcd_digit);
      dp_d  = (digit_q != 2'd2);
      if (blank) begin
         an_d  = 4'b1111;
         seg_d = SEG_BLANK;
         dp_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         scan_cnt_q <= '0;
         digit_q    <= 2'd0;
         min_q      <= 6'd0;
         sec_q      <= 6'd0;
         state_q    <= ST_ON;
         phase_q    <= '0;
         an_q       <= 4'b1111;
         seg_q      <= SEG_BLANK;
         dp_q       <= 1'b1;
      end else begin
         scan_cnt_q <= scan_tc ? '0 : scan_cnt_q + 1'b1;
         if (scan_tc) digit_q <= digit_q + 2'd1;
         // Snapshot only at frame boundary so a frame never mixes old and new time.
         if (frame_wrap) begin
            min_q <= minutes;
            sec_q <= seconds;
         end
         if (!blink) begin
            state_q <= ST_ON;
            phase_q <= '0;
         end else if (tick_1k) begin
            if (phase_q == PHASE_LAST) begin
               phase_q <= '0;
               state_q <= (state_q == ST_ON) ? ST_OFF : ST_ON;
            end else begin
               phase_q <= phase_q + 1'b1;
            end
         end
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_timer_display.sv
// Bench for timer_display: cycle-level reference model feeds a scoreboard queue,
// plus directed frame checks against literal segment codes.
module tb_timer_display;

   localparam int SD = 4;
   localparam int BH = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick_1k;
   logic       en;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic       blink;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   timer_display #(.SCAN_DIV(SD), .BLINK_HALF_MS(BH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick_1k (tick_1k),
      .en      (en),
      .minutes (minutes),
      .seconds (seconds),
      .blink   (blink),
      .an      (an),
      .seg     (seg),
      .dp      (dp)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   int m_cnt, m_dig, m_min, m_sec, m_off, m_ph;
   logic [11:0] exp_q[$];

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] ref_seg(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // One clock: model predicts the registered outputs of this edge, DUT is compared after it.
   task automatic step();
      logic [3:0]  ea;
      logic [6:0]  es;
      logic        ed;
      logic [11:0] got;
      int          v;
      ea = 4'b1111; es = 7'b1111111; ed = 1'b1;
      if (!rst_n) begin
         m_cnt = 0; m_dig = 0; m_min = 0; m_sec = 0; m_off = 0; m_ph = 0;
      end else begin
         if (en && !m_off) begin
            v  = (m_dig >= 2) ? m_min : m_sec;
            ea = ~(4'b0001 << m_dig);
            if (v >= 60) es = 7'b0111111;
            else es = ref_seg((m_dig % 2 == 1) ? v / 10 : v % 10);
            ed = (m_dig == 2) ? 1'b0 : 1'b1;
         end
         if (m_cnt == SD - 1) begin
            if (m_dig == 3) begin
               m_min = int'(minutes);
               m_sec = int'(seconds);
            end
            m_cnt = 0;
            m_dig = (m_dig + 1) % 4;
         end else begin
            m_cnt++;
         end
         if (!blink) begin
            m_off = 0; m_ph = 0;
         end else if (tick_1k) begin
            if (m_ph == BH - 1) begin
               m_ph  = 0;
               m_off = 1 - m_off;
            end else begin
               m_ph++;
            end
         end
      end
      exp_q.push_back({ea, es, ed});
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      chk("sb", {an, seg, dp}, got);
   endtask

   // 16 cycles of one frame against literal codes; optionally change seconds once digit 1 is active.
   task automatic frame_chk(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input int new_sec);
      logic [6:0] s;
      for (int d = 0; d < 4; d++) begin
         s = (d == 0) ? s0 : (d == 1) ? s1 : (d == 2) ? s2 : s3;
         if (d == 1 && new_sec >= 0) seconds = 6'(new_sec);
         for (int c = 0; c < SD; c++) begin
            step();
            chk(tag, {an, seg, dp}, {~(4'b0001 << d), s, (d == 2) ? 1'b0 : 1'b1});
         end
      end
   endtask

   task automatic tick_step();
      tick_1k = 1'b1;
      step();
      tick_1k = 1'b0;
      step();
      step();
   endtask

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                          S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                          S9 = 7'b0010000, SDASH = 7'b0111111;

   initial begin
      rst_n = 1'b0; tick_1k = 1'b0; en = 1'b1; blink = 1'b0;
      minutes = 6'd12; seconds = 6'd34;
      m_cnt = 0; m_dig = 0; m_min = 0; m_sec = 0; m_off = 0; m_ph = 0;

      repeat (3) step();
      chk("rst_out", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});

      rst_n = 1'b1;
      frame_chk("f_0000", S0, S0, S0, S0, -1);
      frame_chk("f_1234", S4, S3, S2, S1, 35);
      frame_chk("f_1235", S5, S3, S2, S1, -1);
      minutes = 6'd63; seconds = 6'd59;
      frame_chk("f_hold", S5, S3, S2, S1, -1);
      frame_chk("f_oor", S9, S5, SDASH, SDASH, -1);

      minutes = 6'd7; seconds = 6'd48;
      blink = 1'b1;
      tick_step(); tick_step();
      chk("blink_off", {8'd0, an}, {8'd0, 4'b1111});
      tick_step(); tick_step();
      chk("blink_on", {11'd0, an == 4'b1111}, 12'd0);
      tick_step(); tick_step();
      chk("blink_off2", {8'd0, an}, {8'd0, 4'b1111});
      blink = 1'b0;
      step(); step();
      chk("unblank", {11'd0, an == 4'b1111}, 12'd0);

      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("en_blank", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
      end
      en = 1'b1;
      repeat (20) step();

      blink = 1'b1;
      tick_step(); tick_step();
      chk("mid_off", {8'd0, an}, {8'd0, 4'b1111});
      rst_n = 1'b0;
      step();
      chk("mid_rst", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
      rst_n = 1'b1;
      step();
      chk("rst_on", {11'd0, an == 4'b1111}, 12'd0);

      for (int i = 0; i < 600; i++) begin
         rst_n   = ($urandom_range(0, 79) != 0);
         en      = ($urandom_range(0, 9) != 0);
         tick_1k = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 15) == 0) blink = ~blink;
         if ($urandom_range(0, 7) == 0) minutes = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 7) == 0) seconds = 6'($urandom_range(0, 63));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
